// File: rtl/gpu_pixel_writer.sv
// Pixel-to-framebuffer writer: turns (x, y, color) pixels into single AXI-lite 16-bit writes.
// Optional build macro GPU_PIXEL_CLIP_EN silently drops pixels outside the screen.
module gpu_pixel_writer #(
    parameter int SCREEN_WIDTH  = 400,
    parameter int SCREEN_HEIGHT = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fb_base_address,
    input  logic        re_valid,
    output logic        re_ready,
    input  logic [15:0] re_x,
    input  logic [15:0] re_y,
    input  logic [15:0] re_color,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [31:0] axi_awaddr,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    input  logic        axi_bvalid,
    output logic        axi_bready,
    input  logic [1:0]  axi_bresp,
    output logic        wr_error
);

    typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

    state_t      state, state_next;
    logic        running;
    logic        aw_pend, w_pend;
    logic        re_hs, aw_hs, w_hs, b_hs;
    logic        pix_clip, pix_accept;
    logic [31:0] pix_addr;
    logic        addr_unused;
    logic [31:0] addr_p1, data_p1;
    logic [3:0]  strb_p1;

    function automatic logic [31:0] pixel_addr(input logic [31:0] base,
                                               input logic [15:0] x,
                                               input logic [15:0] y);
        logic [31:0] idx;
        idx = {16'd0, y} * 32'(SCREEN_WIDTH) + {16'd0, x};
        return base + {idx[30:0], 1'b0};
    endfunction

`ifdef GPU_PIXEL_CLIP_EN
    assign pix_clip = ({16'd0, re_x} >= 32'(SCREEN_WIDTH)) ||
                      ({16'd0, re_y} >= 32'(SCREEN_HEIGHT));
`else
    assign pix_clip = 1'b0;
`endif

    // re_ready is held low for one cycle after reset releases so reset is visible downstream
    assign re_ready    = running && (state == IDLE);
    assign re_hs       = re_valid && re_ready;
    assign pix_accept  = re_hs && !pix_clip;
    assign aw_hs       = axi_awvalid && axi_awready;
    assign w_hs        = axi_wvalid && axi_wready;
    assign b_hs        = axi_bvalid && axi_bready;

    assign pix_addr    = pixel_addr(fb_base_address, re_x, re_y);
    assign addr_unused = pix_addr[0];

    assign axi_awvalid = aw_pend;
    assign axi_wvalid  = w_pend;
    assign axi_bready  = (state == RESP);
    assign axi_awaddr  = addr_p1;
    assign axi_wdata   = data_p1;
    assign axi_wstrb   = strb_p1;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (pix_accept) state_next = WRITE;
            WRITE:   if ((!aw_pend || aw_hs) && (!w_pend || w_hs)) state_next = RESP;
            RESP:    if (b_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            running  <= 1'b0;
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            wr_error <= 1'b0;
        end else begin
            state   <= state_next;
            running <= 1'b1;
            if (pix_accept) begin
                aw_pend <= 1'b1;
                w_pend  <= 1'b1;
            end else begin
                if (aw_hs) aw_pend <= 1'b0;
                if (w_hs)  w_pend  <= 1'b0;
            end
            if (b_hs && (axi_bresp != 2'b00)) wr_error <= 1'b1;
        end
    end

    // stage p1: address/data captured on pixel acceptance, stable until the next pixel
    always_ff @(posedge clk) begin
        if (pix_accept) begin
            addr_p1 <= {pix_addr[31:2], 2'b00};
            data_p1 <= {re_color, re_color};
            strb_p1 <= pix_addr[1] ? 4'b1100 : 4'b0011;
        end
    end

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Randomized bench for gpu_pixel_writer with a transaction-level framebuffer address model
// and a reactive AXI-lite slave with random ready/response delays.
module tb_gpu_pixel_writer;

    localparam int SW = 400;
    localparam int SH = 240;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fb_base_address;
    logic        re_valid, re_ready;
    logic [15:0] re_x, re_y, re_color;
    logic        axi_awvalid, axi_awready;
    logic [31:0] axi_awaddr;
    logic        axi_wvalid, axi_wready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_bvalid, axi_bready;
    logic [1:0]  axi_bresp;
    logic        wr_error;

    int n_checks = 0;
    int n_pass   = 0;
    logic exp_err = 1'b0;

    gpu_pixel_writer #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)) dut (
        .clk(clk), .rst(rst), .fb_base_address(fb_base_address),
        .re_valid(re_valid), .re_ready(re_ready),
        .re_x(re_x), .re_y(re_y), .re_color(re_color),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .wr_error(wr_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_addr(input logic [31:0] base, input int x, input int y);
        longint unsigned a;
        a = longint'(base) + 2 * (longint'(y) * SW + longint'(x));
        return a[31:0];
    endfunction

    function automatic bit model_clip(input int x, input int y);
`ifdef GPU_PIXEL_CLIP_EN
        return (x >= SW) || (y >= SH);
`else
        return 1'b0;
`endif
    endfunction

    task automatic pixel(input logic [31:0] base, input int x, input int y, input logic [15:0] color,
                         input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] resp);
        logic [31:0] a, exp_word, exp_data;
        logic [3:0]  exp_strb;
        bit aw_done, w_done, b_done, aw_hs, w_hs, b_hs;
        int cyc;
        a        = model_addr(base, x, y);
        exp_word = a & 32'hFFFF_FFFC;
        exp_data = {color, color};
        exp_strb = a[1] ? 4'b1100 : 4'b0011;

        check("re_ready_idle", re_ready, 1);
        fb_base_address = base;
        re_x = x[15:0]; re_y = y[15:0]; re_color = color;
        re_valid = 1'b1;
        step();
        re_valid = 1'b0;
        fb_base_address = $urandom;

        if (model_clip(x, y)) begin
            check("clip_re_ready", re_ready, 1);
            check("clip_awvalid", axi_awvalid, 0);
            step();
            check("clip_wvalid", axi_wvalid, 0);
            return;
        end

        check("accept_re_ready", re_ready, 0);
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 60) begin
            axi_awready = !aw_done && (cyc >= aw_dly);
            axi_wready  = !w_done && (cyc >= w_dly);
            axi_bvalid  = 1'($urandom_range(0, 1));
            axi_bresp   = 2'b10;
            check("awvalid", axi_awvalid, !aw_done);
            check("wvalid", axi_wvalid, !w_done);
            check("bready_early", axi_bready, 0);
            check("re_ready_busy", re_ready, 0);
            if (axi_awvalid) check("awaddr", axi_awaddr, exp_word);
            if (axi_wvalid) begin
                check("wdata", axi_wdata, exp_data);
                check("wstrb", axi_wstrb, exp_strb);
            end
            aw_hs = axi_awvalid && axi_awready;
            w_hs  = axi_wvalid && axi_wready;
            step();
            aw_done = aw_done || aw_hs;
            w_done  = w_done || w_hs;
            cyc++;
        end
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 2'b00;
        if (!(aw_done && w_done)) check("aw_w_timeout", 0, 1);
        check("resp_bready", axi_bready, 1);
        check("resp_awvalid", axi_awvalid, 0);
        check("resp_wvalid", axi_wvalid, 0);
        check("wr_error_write", wr_error, exp_err);

        b_done = 0; cyc = 0;
        while (!b_done && cyc < 60) begin
            axi_bvalid = (cyc >= b_dly);
            axi_bresp  = axi_bvalid ? resp : 2'($urandom_range(1, 3));
            check("bready_wait", axi_bready, 1);
            b_hs = axi_bvalid && axi_bready;
            step();
            b_done = b_hs;
            cyc++;
        end
        axi_bvalid = 0; axi_bresp = 2'b00;
        if (!b_done) check("b_timeout", 0, 1);
        if (resp != 2'b00) exp_err = 1'b1;
        check("post_b_bready", axi_bready, 0);
        check("post_b_re_ready", re_ready, 1);
        check("wr_error", wr_error, exp_err);
    endtask

    initial begin
        rst = 1'b1;
        fb_base_address = 0; re_valid = 0; re_x = 0; re_y = 0; re_color = 0;
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 2'b00;
        step(); step();
        check("rst_re_ready", re_ready, 0);
        check("rst_awvalid", axi_awvalid, 0);
        check("rst_wvalid", axi_wvalid, 0);
        check("rst_bready", axi_bready, 0);
        check("rst_wr_error", wr_error, 0);
        rst = 1'b0;
        step();
        check("post_rst_re_ready", re_ready, 1);

        // directed: odd-x high half, next-line low half, slow AW, error response
        pixel(32'h1000_0000, 1, 0, 16'hABCD, 0, 0, 0, 2'b00);
        pixel(32'h1000_0000, 0, 1, 16'h1234, 0, 0, 1, 2'b00);
        pixel(32'h1000_0000, 7, 3, 16'h5A5A, 5, 0, 2, 2'b00);
        pixel(32'h1000_0000, 2, 2, 16'h0F0F, 0, 4, 0, 2'b10);
        pixel(32'h1000_0000, 3, 2, 16'h1111, 1, 1, 0, 2'b00);
        pixel(32'h1000_0000, 400, 0, 16'h2222, 0, 0, 0, 2'b00);
        pixel(32'h1000_0000, 399, 239, 16'h3333, 2, 1, 0, 2'b00);
        pixel(32'hFFFF_FFF0, 65535, 65535, 16'h4444, 0, 0, 0, 2'b00);

        // reset pulse while waiting in RESP
        fb_base_address = 32'h2000_0000; re_x = 5; re_y = 5; re_color = 16'h7777;
        re_valid = 1'b1;
        step();
        re_valid = 1'b0;
        axi_awready = 1; axi_wready = 1;
        step();
        axi_awready = 0; axi_wready = 0;
        step();
        check("pre_rst_bready", axi_bready, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_resp_awvalid", axi_awvalid, 0);
        check("rst_resp_wvalid", axi_wvalid, 0);
        check("rst_resp_bready", axi_bready, 0);
        check("rst_resp_re_ready", re_ready, 0);
        exp_err = 1'b0;
        step();
        check("rst_resp_re_ready_back", re_ready, 1);
        check("rst_resp_wr_error", wr_error, 0);

        for (int i = 0; i < 60; i++) begin
            int x, y;
            x = (i % 5 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 450));
            y = (i % 7 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 270));
            pixel($urandom, x, y, 16'($urandom),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
